// File: rtl/rv32_run_monitor.sv
// Execution monitor for the rv32i multicycle core: flags loops of any period up to
// MAX_PERIOD and optional instruction/cycle limits, with a sticky halt and counters.
module rv32_run_monitor #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned MAX_PERIOD = 4,
    parameter int unsigned LOOP_ITERS = 3,
    parameter int unsigned MAX_CYCLES = 0,
    parameter int unsigned MAX_INSTRS = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ena,
    input  logic                              clear,
    input  logic                              fetch_valid,
    input  logic [PC_W-1:0]                   fetch_pc,
    input  logic                              instruction_done,
    output logic                              halt,
    output logic [1:0]                        halt_reason,
    output logic [$clog2(MAX_PERIOD+1)-1:0]   loop_period,
    output logic [PC_W-1:0]                   loop_pc,
    output logic [31:0]                       cycles,
    output logic [31:0]                       instructions
);

    localparam int unsigned PER_W = $clog2(MAX_PERIOD + 1);
    localparam int unsigned FILL_W = $clog2(MAX_PERIOD + 1);
    localparam int unsigned MAX_M = MAX_PERIOD * LOOP_ITERS;
    localparam int unsigned M_W = (MAX_M < 1) ? 1 : $clog2(MAX_M + 1);

    localparam logic [1:0] REASON_NONE  = 2'd0;
    localparam logic [1:0] REASON_LOOP  = 2'd1;
    localparam logic [1:0] REASON_INSTR = 2'd2;
    localparam logic [1:0] REASON_CYCLE = 2'd3;

    logic [PC_W-1:0]   hist_q [MAX_PERIOD];
    logic [PC_W-1:0]   hist_d [MAX_PERIOD];
    logic [M_W-1:0]    m_q    [MAX_PERIOD];
    logic [M_W-1:0]    m_d    [MAX_PERIOD];
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              halt_q, halt_d;
    logic [1:0]        reason_q, reason_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic [PC_W-1:0]   loop_pc_q, loop_pc_d;
    logic [31:0]       cycles_q, cycles_d;
    logic [31:0]       instrs_q, instrs_d;

    logic              loop_hit;
    logic [PER_W-1:0]  hit_period;
    logic              instr_hit;
    logic              cycle_hit;
    logic [M_W-1:0]    tgt;

    // Next-state: clear beats everything, halt freezes, otherwise count and detect.
    always_comb begin
        hist_d     = hist_q;
        m_d        = m_q;
        fill_d     = fill_q;
        halt_d     = halt_q;
        reason_d   = reason_q;
        period_d   = period_q;
        loop_pc_d  = loop_pc_q;
        cycles_d   = cycles_q;
        instrs_d   = instrs_q;
        loop_hit   = 1'b0;
        hit_period = '0;
        instr_hit  = 1'b0;
        cycle_hit  = 1'b0;
        tgt        = '0;

        if (clear) begin
            hist_d    = '{default: '0};
            m_d       = '{default: '0};
            fill_d    = '0;
            halt_d    = 1'b0;
            reason_d  = REASON_NONE;
            period_d  = '0;
            loop_pc_d = '0;
            cycles_d  = '0;
            instrs_d  = '0;
        end else if (!halt_q) begin
            cycles_d = cycles_q + 32'd1;
            if (instruction_done) begin
                instrs_d = instrs_q + 32'd1;
            end

            if (fetch_valid) begin
                // m[k] counts consecutive fetches equal to the one k fetches back.
                for (int k = 0; k < int'(MAX_PERIOD); k++) begin
                    tgt = M_W'((k + 1) * int'(LOOP_ITERS));
                    if (fill_q >= FILL_W'(k + 1) && fetch_pc == hist_q[k]) begin
                        if (m_q[k] != tgt) begin
                            m_d[k] = m_q[k] + M_W'(1);
                        end
                        if (m_d[k] == tgt && !loop_hit) begin
                            loop_hit   = 1'b1;
                            hit_period = PER_W'(k + 1);
                        end
                    end else begin
                        m_d[k] = '0;
                    end
                end

                hist_d[0] = fetch_pc;
                for (int i = 1; i < int'(MAX_PERIOD); i++) begin
                    hist_d[i] = hist_q[i-1];
                end
                if (fill_q != FILL_W'(MAX_PERIOD)) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end

            instr_hit = (MAX_INSTRS != 0) && instruction_done && (instrs_d == 32'(MAX_INSTRS));
            cycle_hit = (MAX_CYCLES != 0) && (cycles_d == 32'(MAX_CYCLES));

            if (loop_hit) begin
                halt_d    = 1'b1;
                reason_d  = REASON_LOOP;
                period_d  = hit_period;
                loop_pc_d = fetch_pc;
            end else if (instr_hit) begin
                halt_d   = 1'b1;
                reason_d = REASON_INSTR;
            end else if (cycle_hit) begin
                halt_d   = 1'b1;
                reason_d = REASON_CYCLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q    <= '{default: '0};
            m_q       <= '{default: '0};
            fill_q    <= '0;
            halt_q    <= 1'b0;
            reason_q  <= REASON_NONE;
            period_q  <= '0;
            loop_pc_q <= '0;
            cycles_q  <= '0;
            instrs_q  <= '0;
        end else if (ena) begin
            hist_q    <= hist_d;
            m_q       <= m_d;
            fill_q    <= fill_d;
            halt_q    <= halt_d;
            reason_q  <= reason_d;
            period_q  <= period_d;
            loop_pc_q <= loop_pc_d;
            cycles_q  <= cycles_d;
            instrs_q  <= instrs_d;
        end
    end

    assign halt         = halt_q;
    assign halt_reason  = reason_q;
    assign loop_period  = period_q;
    assign loop_pc      = loop_pc_q;
    assign cycles       = cycles_q;
    assign instructions = instrs_q;

endmodule

// File: tb/tb_rv32_run_monitor.sv
// Scoreboard bench for rv32_run_monitor: a window-based reference model predicts
// each edge's outputs, which are queued and compared on the following negedge.
module tb_rv32_run_monitor;

    localparam int unsigned MAXP  = 4;
    localparam int unsigned ITERS = 3;
    localparam int unsigned MAXC  = 20;
    localparam int unsigned MAXI  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        clear;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        instruction_done;
    logic        halt;
    logic [1:0]  halt_reason;
    logic [2:0]  loop_period;
    logic [31:0] loop_pc;
    logic [31:0] cycles;
    logic [31:0] instructions;

    always #5 clk = ~clk;

    rv32_run_monitor #(
        .PC_W(32), .MAX_PERIOD(MAXP), .LOOP_ITERS(ITERS),
        .MAX_CYCLES(MAXC), .MAX_INSTRS(MAXI)
    ) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .clear(clear),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .instruction_done(instruction_done),
        .halt(halt), .halt_reason(halt_reason), .loop_period(loop_period),
        .loop_pc(loop_pc), .cycles(cycles), .instructions(instructions)
    );

    typedef struct {
        logic [31:0] halt;
        logic [31:0] reason;
        logic [31:0] period;
        logic [31:0] lpc;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pcs[$];
    logic [31:0] m_halt, m_reason, m_period, m_lpc, m_cyc, m_ins;
    int          checks = 0;
    int          failures = 0;
    string       cur = "init";

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        pcs.delete();
        m_halt = 0; m_reason = 0; m_period = 0; m_lpc = 0; m_cyc = 0; m_ins = 0;
    endtask

    // Smallest k whose last k*(ITERS+1) fetches since clear repeat with period k.
    function automatic logic [31:0] loop_period_of();
        int n = pcs.size();
        for (int k = 1; k <= int'(MAXP); k++) begin
            if (n >= k * (int'(ITERS) + 1)) begin
                bit ok = 1'b1;
                for (int i = n - k * int'(ITERS); i < n; i++) begin
                    if (pcs[i] != pcs[i-k]) ok = 1'b0;
                end
                if (ok) return 32'(k);
            end
        end
        return 32'd0;
    endfunction

    task automatic check_outputs(input string tag, input exp_t x);
        check_eq({tag, ".halt"},   32'(halt),         x.halt);
        check_eq({tag, ".reason"}, 32'(halt_reason),  x.reason);
        check_eq({tag, ".period"}, 32'(loop_period),  x.period);
        check_eq({tag, ".loop_pc"}, loop_pc,          x.lpc);
        check_eq({tag, ".cycles"}, cycles,            x.cyc);
        check_eq({tag, ".instrs"}, instructions,      x.ins);
    endtask

    task automatic check_zero(input string tag);
        exp_t z;
        z = '{0, 0, 0, 0, 0, 0};
        check_outputs(tag, z);
    endtask

    // Drive one cycle of inputs, predict the edge, then compare after it.
    task automatic step(input logic e, input logic c, input logic fv,
                        input logic [31:0] pc, input logic d);
        exp_t        x;
        logic [31:0] lp;
        ena = e; clear = c; fetch_valid = fv; fetch_pc = pc; instruction_done = d;
        if (e) begin
            if (c) begin
                model_clear();
            end else if (m_halt == 0) begin
                m_cyc = m_cyc + 1;
                if (d) m_ins = m_ins + 1;
                lp = 0;
                if (fv) begin
                    pcs.push_back(pc);
                    lp = loop_period_of();
                end
                if (lp != 0) begin
                    m_halt = 1; m_reason = 1; m_period = lp; m_lpc = pc;
                end else if (d && m_ins == MAXI) begin
                    m_halt = 1; m_reason = 2;
                end else if (m_cyc == MAXC) begin
                    m_halt = 1; m_reason = 3;
                end
            end
        end
        x = '{m_halt, m_reason, m_period, m_lpc, m_cyc, m_ins};
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_eq({cur, ".queue"}, 32'd0, 32'd1);
        end else begin
            check_outputs(cur, exp_q.pop_front());
        end
    endtask

    task automatic fetch(input logic [31:0] pc);
        step(1'b1, 1'b0, 1'b1, pc, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; clear = 1'b0; fetch_valid = 1'b0;
        fetch_pc = '0; instruction_done = 1'b0;
        model_clear();
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        cur = "self_loop";
        do_clear();
        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'h8); fetch(32'h8);
        check_eq("self_loop.third_no_halt", 32'(halt), 32'd0);
        fetch(32'h8);
        check_eq("self_loop.halt", 32'(halt), 32'd1);
        check_eq("self_loop.reason", 32'(halt_reason), 32'd1);
        check_eq("self_loop.period", 32'(loop_period), 32'd1);
        check_eq("self_loop.pc", loop_pc, 32'h8);

        cur = "period2";
        do_clear();
        for (int i = 0; i < 8; i++) begin
            fetch((i % 2 == 0) ? 32'h10 : 32'h14);
            if (i == 6) check_eq("period2.seven_no_halt", 32'(halt), 32'd0);
        end
        check_eq("period2.halt", 32'(halt), 32'd1);
        check_eq("period2.period", 32'(loop_period), 32'd2);
        check_eq("period2.pc", loop_pc, 32'h14);

        cur = "broken";
        do_clear();
        fetch(32'h8); fetch(32'h8); fetch(32'h8); fetch(32'hC);
        fetch(32'h8); fetch(32'h8); fetch(32'h8);
        check_eq("broken.no_halt", 32'(halt), 32'd0);
        fetch(32'h8);
        check_eq("broken.halt", 32'(halt), 32'd1);
        check_eq("broken.period", 32'(loop_period), 32'd1);

        cur = "ena_low";
        do_clear();
        fetch(32'h20); fetch(32'h24); fetch(32'h28);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'h28, 1'b1);
        check_eq("ena_low.cycles", cycles, 32'd3);

        cur = "cycle_limit";
        do_clear();
        for (int i = 0; i < 20; i++) fetch(32'h1000 + 32'(4 * i));
        check_eq("cycle_limit.reason", 32'(halt_reason), 32'd3);
        check_eq("cycle_limit.cycles", cycles, 32'd20);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 32'h50, 1'b1);
        check_eq("cycle_limit.frozen", cycles, 32'd20);

        cur = "instr_limit";
        do_clear();
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b1, 32'h2000 + 32'(4 * i), i % 3 == 2);
        check_eq("instr_limit.reason", 32'(halt_reason), 32'd2);
        check_eq("instr_limit.instrs", instructions, 32'd5);

        cur = "priority";
        do_clear();
        for (int i = 0; i < 16; i++) fetch(32'h100 + 32'(4 * i));
        for (int i = 0; i < 4; i++) fetch(32'h200);
        check_eq("priority.cycles", cycles, 32'd20);
        check_eq("priority.reason", 32'(halt_reason), 32'd1);

        cur = "rst_mid";
        do_clear();
        fetch(32'h40); fetch(32'h40); fetch(32'h40);
        ena = 1'b0; fetch_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("rst_mid.during");
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        fetch(32'h40); fetch(32'h40); fetch(32'h40);
        check_eq("rst_mid.no_halt", 32'(halt), 32'd0);

        cur = "clear_mid";
        do_clear();
        fetch(32'h40); fetch(32'h40); fetch(32'h40);
        do_clear();
        fetch(32'h40); fetch(32'h40); fetch(32'h40);
        check_eq("clear_mid.no_halt", 32'(halt), 32'd0);

        cur = "unfreeze";
        do_clear();
        for (int i = 0; i < 4; i++) fetch(32'h60);
        check_eq("unfreeze.halted", 32'(halt), 32'd1);
        do_clear();
        check_eq("unfreeze.cleared", 32'(halt), 32'd0);
        fetch(32'h64);
        check_eq("unfreeze.counting", cycles, 32'd1);

        ena = 1'b0; fetch_valid = 1'b0; instruction_done = 1'b0;
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32_run_monitor.md
Name: rv32_run_monitor

Overview:
- Synthesizable execution monitor that sits beside the rv32i multicycle core, in the simulator top and in FPGA builds, and decides when a run must stop.
- Three stop conditions:
  - an infinite loop of any period from 1 to MAX_PERIOD fetched PCs;
  - an instruction-count limit;
  - a cycle-count limit.
- Generalises the fixed period-1, 4-sample loop check to a configurable period and repeat count. Exposes sticky halt status plus counters for reporting.

Parameters:
PC_W, 32, width of fetch_pc and loop_pc.
MAX_PERIOD, 4, longest loop period detected, in fetches; must be at least 1.
LOOP_ITERS, 3, extra matching repetitions required; period-k loop flagged after k*(LOOP_ITERS+1) fetches forming the repeated pattern.
MAX_CYCLES, 0, cycle limit; 0 disables.
MAX_INSTRS, 0, instruction limit; 0 disables.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ena  in  1  global enable; when low, no state changes
clear  in  1  synchronous soft clear; same effect as reset at the next edge
fetch_valid  in  1  core is in S_FETCH this cycle; fetch_pc is sampled
fetch_pc  in  PC_W  PC of the fetch
instruction_done  in  1  one-cycle pulse per retired instruction
halt  out  1  sticky stop request
halt_reason  out  2  0 none, 1 loop, 2 instruction limit, 3 cycle limit
loop_period  out  clog2(MAX_PERIOD+1)  detected loop period; 0 if not a loop halt
loop_pc  out  PC_W  fetch_pc that completed the detection
cycles  out  32  enabled, non-halted cycles since reset/clear
instructions  out  32  retired-instruction count

Behaviour:
- Reset (rst high, asynchronous) clears everything immediately. All outputs read 0, the history is emptied and all match counters are 0.
- clear high with ena high has the identical effect at the next posedge. clear takes priority over all other updates.
- Updates happen only on a posedge with ena=1, halt=0 and clear=0. Once halt=1, all state and outputs freeze until rst or clear.
- History: MAX_PERIOD-entry shift register of past fetch PCs plus a fill count. The fill count saturates at MAX_PERIOD.
- Match counters: one counter m_k per period k, k=1..MAX_PERIOD, saturating at k*LOOP_ITERS. On each fetch_valid:
  - if fill count is at least k and fetch_pc equals the PC fetched k fetches earlier (history entry k-1), m_k increments;
  - otherwise m_k is set to 0.
  - The shift register then shifts fetch_pc in.
- Loop detection: a loop is detected on the edge where some m_k reaches k*LOOP_ITERS. If several periods hit on the same edge, the smallest k wins; loop_period=k.
  - Default period 1: four consecutive equal PCs trigger.
- Instruction limit (MAX_INSTRS≠0):
  - instructions increments on each instruction_done.
  - A limit hit occurs on the edge where instructions becomes MAX_INSTRS.
- Cycle limit (MAX_CYCLES≠0):
  - cycles increments every updating edge.
  - A limit hit occurs on the edge where cycles becomes MAX_CYCLES.
- On a hit edge, in a single posedge:
  - halt becomes 1;
  - halt_reason is set by priority: loop(1) > instruction(2) > cycle(3);
  - loop_pc and loop_period are loaded only for a loop halt;
  - counters take their incremented values on that same edge.
- Latency: halt is registered. It is visible in the cycle after the triggering posedge samples the inputs, with no combinational path from inputs to halt.
- Counters are 32-bit and wrap modulo 2^32 when their limit is disabled.
- fetch_valid low: the history and m_k hold.
- ena low: cycles does not count, and inputs are ignored.
- fetch_valid and instruction_done in the same cycle are both processed.

Test Plan:
- Self-loop: fetch PCs 0x0,0x4,0x8,0x8,0x8,0x8. Required: halt=1 after the edge sampling the 4th 0x8 (not the 3rd); halt_reason=1, loop_period=1, loop_pc=0x8.
- Period 2: alternate 0x10,0x14 for 8 fetches. Required: after 7 fetches halt=0; after the 8th, halt=1, loop_period=2, loop_pc=0x14.
- Broken pattern: 0x8,0x8,0x8,0xC,0x8,0x8,0x8. Required: halt stays 0. Adding one more 0x8 then triggers period 1.
- Limits: with MAX_CYCLES=20 and incrementing PCs, halt=1 with reason 3 and cycles=20, then frozen for 10 more cycles. With MAX_INSTRS=5 and a retire every 3 cycles, reason 2 and instructions=5.
- Priority: MAX_CYCLES timed so the 4th equal PC lands on cycle 20. Required: halt_reason=1.
- Reset/clear mid-run: 3 equal PCs, then rst pulsed between edges, then 3 more equal PCs. Required: all outputs 0 during rst and no halt afterwards. Repeat with clear: same result, and a halted monitor unfreezes after clear.
